// File: rtl/muldiv_ctl_if.sv
// EX-stage / ALU handshake bundle for muldiv_ctl.
// master = pipeline plus ALU side, slave = the controller.
interface muldiv_ctl_if;
    logic       exvalid;
    logic [2:0] exop;
    logic       exflush;
    logic       alubusy;
    logic       alugo;
    logic       exstall;
    logic       flushok;
    logic       busy;
    logic       wdtfault;

    modport master (
        output exvalid, exop, exflush, alubusy,
        input  alugo, exstall, flushok, busy, wdtfault
    );

    modport slave (
        input  exvalid, exop, exflush, alubusy,
        output alugo, exstall, flushok, busy, wdtfault
    );
endinterface

// File: rtl/muldiv_ctl.sv
// Launch/interlock sequencer between EX and the multiply/divide unit, with latency watchdog.
// Define MULDIV_CTL_PERF_EN to add the launch and stall performance counters.
module muldiv_ctl #(
    parameter int unsigned MAXLAT = 72,
    parameter int unsigned CTRW   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phi2_i,
`ifdef MULDIV_CTL_PERF_EN
    output logic [31:0] perfops_o,
    output logic [31:0] perfstall_o,
`endif
    muldiv_ctl_if.slave bus
);
    typedef enum logic [1:0] {StRstw, StIdle, StRun} state_e;

    state_e          state_q;
    logic [CTRW-1:0] ctr_q;
    logic            wdt_q;
    logic            busy_q;
    logic            op_md;
    logic            op_hilo;
    logic            launch;

    always_comb begin
        op_md       = bus.exvalid && (bus.exop == 3'd1 || bus.exop == 3'd2);
        op_hilo     = bus.exvalid && (bus.exop == 3'd3 || bus.exop == 3'd4);
        launch      = 1'b0;
        bus.alugo   = 1'b0;
        bus.exstall = 1'b1;
        bus.flushok = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StRstw: begin
                    bus.exstall = op_md || op_hilo;
                    bus.flushok = !bus.alubusy;
                end
                StIdle: begin
                    // A pending flush or a unit that never went idle blocks the launch.
                    launch      = op_md && !bus.exflush && !bus.alubusy;
                    bus.alugo   = launch;
                    bus.exstall = launch || (bus.alubusy && (op_md || op_hilo));
                    bus.flushok = 1'b1;
                end
                StRun: begin
                    bus.exstall = bus.alubusy;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRstw;
            ctr_q   <= '0;
            wdt_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else if (phi2_i) begin
            unique case (state_q)
                StRstw: begin
                    if (!bus.alubusy) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StIdle: begin
                    if (launch) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        ctr_q   <= '0;
                    end
                end
                StRun: begin
                    if (ctr_q != '1) ctr_q <= ctr_q + 1'b1;
                    if (!bus.alubusy) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (ctr_q == CTRW'(MAXLAT)) begin
                        // Unit overran its budget: wait for it to drain like after reset.
                        wdt_q   <= 1'b1;
                        state_q <= StRstw;
                    end
                end
                default: begin
                    state_q <= StRstw;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.wdtfault = wdt_q;

`ifdef MULDIV_CTL_PERF_EN
    logic [31:0] perfops_q;
    logic [31:0] perfstall_q;

    // The launch phase stalls on behalf of the unit, so it is counted with the RUN phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfops_q   <= '0;
            perfstall_q <= '0;
        end else if (phi2_i) begin
            if (launch) perfops_q <= perfops_q + 32'd1;
            if (bus.exstall && (state_q != StIdle || launch)) perfstall_q <= perfstall_q + 32'd1;
        end
    end

    assign perfops_o   = perfops_q;
    assign perfstall_o = perfstall_q;
`endif
endmodule

// File: tb/tb_muldiv_ctl.sv
// Self-checking bench for muldiv_ctl: directed scenarios plus randomized phases vs a reference model.
module tb_muldiv_ctl;
    localparam int unsigned MAXLAT = 72;
    localparam int unsigned CTRW   = 7;
    localparam int unsigned WDLAT  = 8;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_w = 1'b1;
    logic phi2  = 1'b1;

    muldiv_ctl_if m_if ();
    muldiv_ctl_if w_if ();

`ifdef MULDIV_CTL_PERF_EN
    logic [31:0] perfops;
    logic [31:0] perfstall;
    logic [31:0] perfops_w;
    logic [31:0] perfstall_w;
`endif

    muldiv_ctl #(.MAXLAT(MAXLAT), .CTRW(CTRW)) dut (
        .clk         (clk),
        .rst         (rst),
        .phi2_i      (phi2),
`ifdef MULDIV_CTL_PERF_EN
        .perfops_o   (perfops),
        .perfstall_o (perfstall),
`endif
        .bus         (m_if)
    );

    muldiv_ctl #(.MAXLAT(WDLAT), .CTRW(CTRW)) dut_w (
        .clk         (clk),
        .rst         (rst_w),
        .phi2_i      (phi2),
`ifdef MULDIV_CTL_PERF_EN
        .perfops_o   (perfops_w),
        .perfstall_o (perfstall_w),
`endif
        .bus         (w_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the controller is waiting for, and how long the unit has run.
    bit          m_drain;
    bit          m_run;
    bit          m_fault;
    int          m_runs;
    int unsigned m_ops;
    int unsigned m_stalls;
    // ALU model: busy phases remaining; it has no reset.
    int          alu_rem = 0;
    int          next_lat = 1;
    logic [4:0]  exp_v;
    bit          exp_go;
    bit          exp_st;

    function automatic logic [4:0] obs_m();
        return {m_if.alugo, m_if.exstall, m_if.flushok, m_if.busy, m_if.wdtfault};
    endfunction

    function automatic logic [4:0] obs_w();
        return {w_if.alugo, w_if.exstall, w_if.flushok, w_if.busy, w_if.wdtfault};
    endfunction

    function automatic void model_reset();
        m_drain  = 1'b1;
        m_run    = 1'b0;
        m_fault  = 1'b0;
        m_runs   = 0;
        m_ops    = 0;
        m_stalls = 0;
    endfunction

    // Drive one phase of inputs and derive the expected {alugo,exstall,flushok,busy,wdtfault}.
    task automatic apply(input bit v, input logic [2:0] op, input bit fl, input bit ph);
        bit md, hl, go, st, fo, ab;
        m_if.exvalid = v;
        m_if.exop    = op;
        m_if.exflush = fl;
        phi2         = ph;
        ab           = (alu_rem > 0);
        m_if.alubusy = ab;
        md = v && (op == 3'd1 || op == 3'd2);
        hl = v && (op == 3'd3 || op == 3'd4);
        if (rst) begin
            model_reset();
            go = 1'b0; st = 1'b1; fo = 1'b0;
        end else if (m_drain) begin
            go = 1'b0; st = md || hl; fo = !ab;
        end else if (m_run) begin
            go = 1'b0; st = ab; fo = 1'b0;
        end else begin
            go = md && !fl && !ab; st = go || (ab && (md || hl)); fo = 1'b1;
        end
        exp_go = go;
        exp_st = st;
        exp_v  = {go, st, fo, m_drain || m_run, m_fault};
        #3;
    endtask

    task automatic advance();
        bit ab;
        ab = m_if.alubusy;
        @(posedge clk);
        if (phi2 && !rst) begin
            if (exp_st && (m_drain || m_run || exp_go)) m_stalls++;
            if (m_drain) begin
                if (!ab) m_drain = 1'b0;
            end else if (m_run) begin
                if (!ab) m_run = 1'b0;
                else if (m_runs == int'(MAXLAT)) begin
                    m_fault = 1'b1; m_run = 1'b0; m_drain = 1'b1;
                end
                m_runs++;
            end else if (exp_go) begin
                m_run = 1'b1; m_runs = 0; m_ops++;
            end
        end
        if (phi2) begin
            if (exp_go && !rst) alu_rem = next_lat;
            else if (alu_rem > 0) alu_rem--;
        end
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_run || m_drain) && n < 200) begin
            apply(1'b0, 3'd0, 1'b0, 1'b1);
            advance();
            n++;
        end
        if (m_run || m_drain) begin
            n_tests++; n_fail++;
            $display("FAIL drain: controller still busy after %0d phases, required idle", n);
        end
    endtask

    task automatic test_reset();
        apply(1'b0, 3'd0, 1'b0, 1'b1);
        n_tests++;
        if (obs_m() !== 5'b01010) begin
            n_fail++; $display("FAIL reset_hold: got %b want %b", obs_m(), 5'b01010);
        end
        advance();
        rst = 1'b0;
        apply(1'b0, 3'd0, 1'b0, 1'b1);
        n_tests++;
        if (obs_m() !== 5'b00110) begin
            n_fail++; $display("FAIL reset_rstw: got %b want %b", obs_m(), 5'b00110);
        end
        advance();
        for (int k = 0; k < 3; k++) begin
            logic [2:0] op;
            op = 3'(k + 2);
            apply(1'b1, (k == 0) ? 3'd0 : op, 1'b0, 1'b1);
            n_tests++;
            if (obs_m() !== 5'b00100) begin
                n_fail++; $display("FAIL reset_idle k%0d: got %b want %b", k, obs_m(), 5'b00100);
            end
            advance();
        end
    endtask

    task automatic test_mul();
        logic [4:0] want;
        next_lat = 3;
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 3'd1, 1'b0, 1'b1);
            want = {i == 0, i < 4, i == 0, i != 0, 1'b0};
            n_tests++;
            if (obs_m() !== want || exp_v !== want) begin
                n_fail++; $display("FAIL mul ph%0d: got %b want %b", i, obs_m(), want);
            end
            advance();
        end
        apply(1'b0, 3'd0, 1'b0, 1'b1);
        n_tests++;
        if (m_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL mul_busy_after: got %b want 0", m_if.busy);
        end
        advance();
`ifdef MULDIV_CTL_PERF_EN
        n_tests++;
        if (perfops !== 32'd1 || perfstall !== 32'd4) begin
            n_fail++;
            $display("FAIL mul_perf: got ops %0d stall %0d want 1 4", perfops, perfstall);
        end
`endif
    endtask

    task automatic test_phi2();
        next_lat = 3;
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 3'd1, 1'b0, bit'(k % 2));
            n_tests++;
            if (obs_m() !== exp_v) begin
                n_fail++; $display("FAIL phi2 k%0d: got %b want %b", k, obs_m(), exp_v);
            end
            advance();
        end
        apply(1'b0, 3'd0, 1'b0, 1'b0);
        n_tests++;
        if (obs_m() !== 5'b00100) begin
            n_fail++; $display("FAIL phi2_end: got %b want %b", obs_m(), 5'b00100);
        end
        advance();
`ifdef MULDIV_CTL_PERF_EN
        n_tests++;
        if (perfops !== 32'd2 || perfstall !== 32'd8) begin
            n_fail++;
            $display("FAIL phi2_perf: got ops %0d stall %0d want 2 8", perfops, perfstall);
        end
`endif
    endtask

    task automatic test_div_mflo();
        next_lat = 67;
        apply(1'b1, 3'd2, 1'b0, 1'b1);
        n_tests++;
        if (m_if.alugo !== 1'b1) begin
            n_fail++; $display("FAIL div_launch: got alugo %b want 1", m_if.alugo);
        end
        advance();
        for (int i = 1; i <= 68; i++) begin
            apply(1'b1, 3'd2, 1'b0, 1'b1);
            n_tests++;
            if (obs_m() !== exp_v || m_if.exstall !== (i < 68)) begin
                n_fail++; $display("FAIL div ph%0d: got %b want %b", i, obs_m(), exp_v);
            end
            advance();
        end
        apply(1'b1, 3'd3, 1'b0, 1'b1);
        n_tests++;
        if (m_if.exstall !== 1'b0 || m_if.wdtfault !== 1'b0 || m_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL mflo: got %b want %b", obs_m(), 5'b00100);
        end
        advance();
    endtask

    task automatic test_flush();
        apply(1'b1, 3'd1, 1'b1, 1'b1);
        n_tests++;
        if (obs_m() !== 5'b00100) begin
            n_fail++; $display("FAIL flush_idle: got %b want %b", obs_m(), 5'b00100);
        end
        advance();
        next_lat = 4;
        apply(1'b1, 3'd1, 1'b0, 1'b1);
        advance();
        apply(1'b1, 3'd1, 1'b1, 1'b1);
        n_tests++;
        if (obs_m() !== 5'b01010) begin
            n_fail++; $display("FAIL flush_run: got %b want %b", obs_m(), 5'b01010);
        end
        advance();
        drain();
    endtask

    task automatic test_reset_midop();
        bit launched;
        next_lat = 5;
        apply(1'b1, 3'd2, 1'b0, 1'b1);
        advance();
        apply(1'b0, 3'd0, 1'b0, 1'b1);
        advance();
        rst = 1'b1;
        apply(1'b1, 3'd2, 1'b0, 1'b1);
        n_tests++;
        if (obs_m() !== 5'b01010) begin
            n_fail++; $display("FAIL rst_mid: got %b want %b", obs_m(), 5'b01010);
        end
        advance();
        rst = 1'b0;
        launched = 1'b0;
        for (int j = 0; j < 8 && !launched; j++) begin
            apply(1'b1, 3'd2, 1'b0, 1'b1);
            n_tests++;
            if (obs_m() !== exp_v || (j < 3 && obs_m() !== 5'b01010)) begin
                n_fail++; $display("FAIL rst_drain j%0d: got %b want %b", j, obs_m(), exp_v);
            end
            launched = exp_go;
            advance();
        end
        if (!launched) begin
            n_tests++; n_fail++;
            $display("FAIL rst_relaunch: got no launch want launch within 8 phases");
        end
        drain();
    endtask

    task automatic test_watchdog();
        w_if.exvalid = 1'b1; w_if.exop = 3'd1; w_if.alubusy = 1'b0;
        apply(1'b0, 3'd0, 1'b0, 1'b1);
        n_tests++;
        if (obs_w() !== 5'b11100) begin
            n_fail++; $display("FAIL wdt_launch: got %b want %b", obs_w(), 5'b11100);
        end
        advance();
        w_if.exvalid = 1'b0; w_if.alubusy = 1'b1;
        for (int r = 1; r <= 9; r++) begin
            apply(1'b0, 3'd0, 1'b0, 1'b1);
            n_tests++;
            if (obs_w() !== 5'b01010) begin
                n_fail++; $display("FAIL wdt_run r%0d: got %b want %b", r, obs_w(), 5'b01010);
            end
            advance();
        end
        w_if.exvalid = 1'b1; w_if.exop = 3'd1;
        apply(1'b0, 3'd0, 1'b0, 1'b1);
        n_tests++;
        if (obs_w() !== 5'b01011) begin
            n_fail++; $display("FAIL wdt_fault: got %b want %b", obs_w(), 5'b01011);
        end
        advance();
        w_if.alubusy = 1'b0;
        apply(1'b0, 3'd0, 1'b0, 1'b1);
        n_tests++;
        if (obs_w() !== 5'b01111) begin
            n_fail++; $display("FAIL wdt_drain: got %b want %b", obs_w(), 5'b01111);
        end
        advance();
        w_if.exvalid = 1'b0;
        apply(1'b0, 3'd0, 1'b0, 1'b1);
        n_tests++;
        if (obs_w() !== 5'b00101) begin
            n_fail++; $display("FAIL wdt_sticky: got %b want %b", obs_w(), 5'b00101);
        end
        advance();
        rst_w = 1'b1;
        apply(1'b0, 3'd0, 1'b0, 1'b1);
        n_tests++;
        if (obs_w() !== 5'b01010) begin
            n_fail++; $display("FAIL wdt_clear: got %b want %b", obs_w(), 5'b01010);
        end
        advance();
        rst_w = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit v, fl, ph;
            logic [2:0] op;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            v  = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            fl = ($urandom_range(0, 7) == 0);
            ph = ($urandom_range(0, 3) != 0);
            next_lat = ($urandom_range(0, 19) == 0) ? int'($urandom_range(70, 80))
                                                    : int'($urandom_range(1, 12));
            apply(v, op, fl, ph);
            n_tests++;
            if (obs_m() !== exp_v) begin
                n_fail++; $display("FAIL random i%0d: got %b want %b", i, obs_m(), exp_v);
            end
            advance();
        end
        rst = 1'b0;
        drain();
`ifdef MULDIV_CTL_PERF_EN
        n_tests++;
        if (perfops !== 32'(m_ops) || perfstall !== 32'(m_stalls)) begin
            n_fail++;
            $display("FAIL random_perf: got ops %0d stall %0d want %0d %0d",
                     perfops, perfstall, m_ops, m_stalls);
        end
`endif
    endtask

    initial begin
        m_if.exvalid = 1'b0; m_if.exop = 3'd0; m_if.exflush = 1'b0; m_if.alubusy = 1'b0;
        w_if.exvalid = 1'b0; w_if.exop = 3'd0; w_if.exflush = 1'b0; w_if.alubusy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_w = 1'b0;
        test_reset();
        test_mul();
        test_phi2();
        test_div_mflo();
        test_flush();
        test_reset_midop();
        test_watchdog();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
